ctr: RTL and testbench
======================

Name: ctr

Overview:
- Reciprocal frequency/time-interval counter core for the fc100 front end.
- Opens a measurement gate on a selected input edge after a begin request, and closes it on a selected edge after an end request.
- Over the gate it counts input events (cta) and reference clock cycles (ctc).
- Emits begin/end interpolator pulses so an analog interpolator can resolve the fractional clock period; ip0/ip1 inject clock-aligned calibration events.

Parameters:
- W, 32, width of cta/ctc counters
- SYNC, 2, synchronizer depth for input-domain flags into clk domain

Ports:
- clk  in  1  reference clock; all clk-domain logic on rising edge
- rst  in  1  reset, asynchronous, active-high; clears every register in both domains
- ina  in  1  measured input A
- inb  in  1  measured input B
- bis  in  2  begin-event select: 00 ina rise, 01 ina fall, 10 inb rise, 11 inb fall
- eis  in  2  end-event select, same encoding as bis
- brq  in  1  begin request (level)
- erq  in  1  end request (level)
- bac  out 1  begin acknowledge: gate opened (clk-synchronized)
- eac  out 1  end acknowledge: gate closed, results valid (clk-synchronized)
- cta  out W  count of end-source events inside gate
- ctc  out W  count of clk cycles inside gate
- bip  out 1  begin interpolator pulse
- eip  out 1  end interpolator pulse
- bin  out 1  begin interpolator stop (clk-aligned)
- ein  out 1  end interpolator stop (clk-aligned)
- ip0  in  1  calibration event, 1-clk interval
- ip1  in  1  calibration event, 2-clk interval

Behaviour:
- Reset: bac=eac=0, cta=ctc=0, bip=eip=bin=ein=0, gate closed, arm flags cleared. Reset mid-measurement aborts it; a new measurement requires rst low, then a new brq.
- Event sources: the selected edge is the edge of ina/inb (or its inverse) chosen by bis/eis. Begin/end flops are clocked directly by the event signal (asynchronous to clk).
- Begin:
  - brq high (synchronized into the event domain) arms begin.
  - The first selected begin edge after arming sets gate_open and bip.
  - bac rises SYNC clk cycles later and holds until rst.
  - brq falling after bac has no effect.
- End:
  - erq is honoured only while gate_open; it arms end.
  - The first selected end edge after arming clears gate_open and sets eip.
  - eac rises SYNC clk cycles later and holds until rst.
  - erq before begin is held pending and arms once the gate opens.
- Same source/edge for begin and end: the opening edge never also closes the gate; the earliest possible close is the next selected edge.
- cta:
  - Increments on each selected end-source edge while gate_open, including the closing edge, excluding the opening edge.
  - Frequency mode (bis=eis): cta = number of full input periods.
  - Low-time mode (bis=01, eis=00): cta = 1.
- ctc: increments on each clk rising edge while the synchronized gate is open.
- Counter width: both counters wrap modulo 2^W silently, with no overflow flag. Both are frozen and stable once eac=1.
- Interpolator outputs:
  - bip is set asynchronously at the begin event.
  - bin is set at the second clk rising edge after the bip set.
  - Both stay high until rst. The interpolator measures bip-rise to bin-rise.
  - eip/ein behave identically for the end event.
- Calibration:
  - ip0 rising while rst low and idle sets bip and eip on the same clk edge.
  - bin and ein follow 2 clks later, giving a known interval.
  - ip1 does the same, but eip is delayed 1 clk after bip (1-clk vs 2-clk reference).
  - In calibration, cta and ctc stay 0 and bac and eac stay 0.
- Simultaneous brq and erq: begin is processed first; the end closes on the next end edge after opening.

Decomposition:
- Shared package: select encodings (SEL_A_RISE=2'b00, SEL_A_FALL=2'b01, SEL_B_RISE=2'b10, SEL_B_FALL=2'b11) and the default W.
- One sub-module, ctr_edge_sel: muxes ina/inb with optional inversion per select code. Instantiate it twice, once for begin and once for end.

Test Plan:
- Reset: rst=1 -> all outputs 0. Release rst with no stimulus -> outputs stay 0 for 20 clks.
- Calibration 0: ip0 high 50us, clk period 8us -> bip and eip rise on the same clk edge, bin and ein 2 clks later, cta=ctc=0, bac=eac=0.
- Calibration 1: ip1 high 50us -> eip rise lags bip rise by exactly 1 clk, cta=ctc=0.
- Low time: bis=01, eis=00, brq=erq=1 together, ina period 14us -> gate opens on ina fall, closes on the next ina rise, cta=1, ctc in {0,1}, bac then eac asserted.
- Frequency: bis=eis=00, brq, then erq 100us later -> cta equals the ina rises counted from after the opening edge to the closing edge (7 or 8), ctc equals the clk edges spanned (about 13), eac=1, counts stable afterwards.
- Abort: rst asserted mid-gate -> all counts and flags cleared asynchronously, with no eac.

Source files
------------

// File: rtl/ctr_pkg.sv
// Shared definitions for the ctr reciprocal counter core: event-select
// encodings and default sizing.
package ctr_pkg;

  typedef enum logic [1:0] {
    SEL_A_RISE = 2'b00,
    SEL_A_FALL = 2'b01,
    SEL_B_RISE = 2'b10,
    SEL_B_FALL = 2'b11
  } sel_e;

  localparam int W_DEF    = 32;
  localparam int SYNC_DEF = 2;

endpackage

// File: rtl/ctr_edge_sel.sv
// Event source mux: presents the selected input so that the chosen edge
// always appears as a rising edge on ev.
module ctr_edge_sel
  import ctr_pkg::*;
(
  input  logic       ina,
  input  logic       inb,
  input  logic [1:0] sel,
  output logic       ev
);

  // NOTE: assign a default before the case so no path leaves ev unassigned
  // (that would infer a latch).
  always_comb begin
    ev = ina;
    case (sel_e'(sel))
      SEL_A_RISE: ev = ina;
      SEL_A_FALL: ev = ~ina;
      SEL_B_RISE: ev = inb;
      SEL_B_FALL: ev = ~inb;
    endcase
  end

endmodule

// File: rtl/ctr.sv
// Reciprocal frequency / time-interval counter core: an edge-clocked gate,
// event and reference-clock counters, and interpolator start/stop pulses.
module ctr
  import ctr_pkg::*;
#(
  parameter int W    = W_DEF,
  parameter int SYNC = SYNC_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ina,
  input  logic         inb,
  input  logic [1:0]   bis,
  input  logic [1:0]   eis,
  input  logic         brq,
  input  logic         erq,
  output logic         bac,
  output logic         eac,
  output logic [W-1:0] cta,
  output logic [W-1:0] ctc,
  output logic         bip,
  output logic         eip,
  output logic         bin,
  output logic         ein,
  input  logic         ip0,
  input  logic         ip1
);

  logic            bev, eev;
  logic            gbeg, gend;
  logic            barm, earm;
  logic [SYNC-1:0] bsync, esync;
  logic [1:0]      ip0_s, ip1_s;
  logic            ip0_rise, ip1_rise, idle;
  logic            cbip, ceip, ip1_dly;
  logic            bip_s, eip_s;

  ctr_edge_sel u_bsel (.ina(ina), .inb(inb), .sel(bis), .ev(bev));
  ctr_edge_sel u_esel (.ina(ina), .inb(inb), .sel(eis), .ev(eev));

  assign bac      = bsync[SYNC-1];
  assign eac      = esync[SYNC-1];
  assign bip      = gbeg | cbip;
  assign eip      = gend | ceip;
  assign idle     = !barm && !bac;
  assign ip0_rise = ip0_s[0] & ~ip0_s[1];
  assign ip1_rise = ip1_s[0] & ~ip1_s[1];

  // Gate open: first selected begin edge once armed; sticky until rst.
  always_ff @(posedge bev or posedge rst) begin
    if (rst) gbeg <= 1'b0;
    else if (barm) gbeg <= 1'b1;
  end

  // NOTE: non-blocking updates mean that when begin and end share one edge
  // this block still sees gbeg=0 on the opening edge, so that edge is neither
  // counted nor allowed to close the gate.
  always_ff @(posedge eev or posedge rst) begin
    if (rst) begin
      gend <= 1'b0;
      cta  <= '0;
    end else if (gbeg && !gend) begin
      cta <= cta + W'(1);
      if (earm) gend <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      barm    <= 1'b0;
      earm    <= 1'b0;
      bsync   <= '0;
      esync   <= '0;
      ctc     <= '0;
      ip0_s   <= '0;
      ip1_s   <= '0;
      cbip    <= 1'b0;
      ceip    <= 1'b0;
      ip1_dly <= 1'b0;
      bip_s   <= 1'b0;
      eip_s   <= 1'b0;
      bin     <= 1'b0;
      ein     <= 1'b0;
    end else begin
      // Requests are latched so a pending erq waits for the gate to open.
      barm  <= barm | brq;
      earm  <= earm | erq;
      bsync <= (bsync << 1) | SYNC'(gbeg);
      esync <= (esync << 1) | SYNC'(gend);
      if (bac && !eac) ctc <= ctc + W'(1);

      ip0_s   <= {ip0_s[0], ip0};
      ip1_s   <= {ip1_s[0], ip1};
      ip1_dly <= idle && ip1_rise;
      if (idle && (ip0_rise || ip1_rise)) cbip <= 1'b1;
      if ((idle && ip0_rise) || ip1_dly) ceip <= 1'b1;

      // Stops land on the second clk edge after the matching start.
      bip_s <= bip;
      bin   <= bip_s;
      eip_s <= eip;
      ein   <= eip_s;
    end
  end

endmodule

// File: tb/tb_ctr.sv
// Self-checking bench for ctr: reset, calibration, table of gated
// measurements scored through a queue, and a mid-gate abort.
`timescale 1us/1ns
module tb_ctr;
  import ctr_pkg::*;

  localparam int TW   = 4;
  localparam int NTOG = 40;

  logic          clk = 1'b0;
  logic          rst, ina, inb, brq, erq, ip0, ip1;
  logic [1:0]    bis, eis;
  logic          bac, eac, bip, eip, bin, ein;
  logic [TW-1:0] cta, ctc;

  ctr #(.W(TW), .SYNC(2)) dut (
    .clk(clk), .rst(rst), .ina(ina), .inb(inb), .bis(bis), .eis(eis),
    .brq(brq), .erq(erq), .bac(bac), .eac(eac), .cta(cta), .ctc(ctc),
    .bip(bip), .eip(eip), .bin(bin), .ein(ein), .ip0(ip0), .ip1(ip1)
  );

  always #4 clk = ~clk;

  typedef struct {
    logic [1:0] bis;
    logic [1:0] eis;
    int         erq_at;   // toggle index at which erq rises; 0 = with brq
    int         exp_cta;
    int         ctc_lo;
    int         ctc_hi;
  } vec_t;

  typedef struct {
    int id;
    int cta;
    int ctc_lo;
    int ctc_hi;
  } exp_t;

  vec_t vecs[6];
  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input longint act, input longint lo, input longint hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic do_reset(input logic [1:0] b, input logic [1:0] e);
    rst = 1'b1; brq = 1'b0; erq = 1'b0; ina = 1'b0; inb = 1'b0;
    ip0 = 1'b0; ip1 = 1'b0; bis = b; eis = e;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic toggle(input logic useb);
    if (useb) inb = ~inb;
    else      ina = ~ina;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    exp_t e;
    int   n;
    do_reset(v.bis, v.eis);
    @(posedge clk);
    brq = 1'b1;
    if (v.erq_at == 0) erq = 1'b1;
    repeat (2) @(posedge clk);
    #1.5;
    e.id = id; e.cta = v.exp_cta; e.ctc_lo = v.ctc_lo; e.ctc_hi = v.ctc_hi;
    sb.push_back(e);
    for (int t = 1; t <= NTOG; t++) begin
      #7;
      toggle(v.bis[1]);
      if (t == v.erq_at) erq = 1'b1;
    end
    n = 0;
    while (!eac && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check($sformatf("vec%0d eac", id), eac, 1, 1);
    if (sb.size() == 0) begin
      check($sformatf("vec%0d scoreboard empty", id), 0, 1, 1);
    end else begin
      e = sb.pop_front();
      check($sformatf("vec%0d cta", e.id), cta, e.cta, e.cta);
      check($sformatf("vec%0d ctc", e.id), ctc, e.ctc_lo, e.ctc_hi);
      check($sformatf("vec%0d bac/bip/bin/eip/ein", e.id),
            {bac, bip, bin, eip, ein}, 5'b11111, 5'b11111);
      repeat (4) @(negedge clk);
      check($sformatf("vec%0d ctc frozen", e.id), ctc, e.ctc_lo, e.ctc_hi);
    end
  endtask

  task automatic run_cal(input logic use1);
    int bip_c, eip_c, bin_c, ein_c;
    bip_c = -1; eip_c = -1; bin_c = -1; ein_c = -1;
    do_reset(2'b00, 2'b00);
    @(negedge clk);
    #0.5;
    if (use1) ip1 = 1'b1;
    else      ip0 = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c == 6) begin ip0 = 1'b0; ip1 = 1'b0; end
      if (bip && bip_c < 0) bip_c = c;
      if (eip && eip_c < 0) eip_c = c;
      if (bin && bin_c < 0) bin_c = c;
      if (ein && ein_c < 0) ein_c = c;
    end
    check($sformatf("cal%0d bip rise", use1), bip_c, 0, 3);
    check($sformatf("cal%0d eip lag", use1), eip_c - bip_c, use1 ? 1 : 0, use1 ? 1 : 0);
    check($sformatf("cal%0d bin lag", use1), bin_c - bip_c, 2, 2);
    check($sformatf("cal%0d ein lag", use1), ein_c - eip_c, 2, 2);
    check($sformatf("cal%0d cta", use1), cta, 0, 0);
    check($sformatf("cal%0d ctc", use1), ctc, 0, 0);
    check($sformatf("cal%0d bac/eac", use1), {bac, eac}, 0, 0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic seen;
    rst = 1'b1; brq = 1'b0; erq = 1'b0; ina = 1'b0; inb = 1'b0;
    ip0 = 1'b0; ip1 = 1'b0; bis = 2'b00; eis = 2'b00;

    //           bis    eis    erq_at cta ctc_lo ctc_hi
    vecs[0] = '{2'b00, 2'b00, 13,    7,  12,    13};  // frequency, 7 periods
    vecs[1] = '{2'b01, 2'b00, 0,     1,  0,     1};   // low time
    vecs[2] = '{2'b11, 2'b11, 0,     1,  1,     2};   // B fall, erq pending
    vecs[3] = '{2'b10, 2'b10, 5,     3,  5,     6};   // B rise, 3 periods
    vecs[4] = '{2'b00, 2'b01, 0,     1,  0,     1};   // high time
    vecs[5] = '{2'b00, 2'b00, 33,    1,  13,    14};  // 17 periods, 4-bit wrap

    // Reset state and quiet idle.
    repeat (2) @(posedge clk);
    #1;
    check("reset flags", {bac, eac, bip, eip, bin, ein}, 0, 0);
    check("reset counts", {cta, ctc}, 0, 0);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if ({bac, eac, bip, eip, bin, ein} != 6'b0 || cta != 0 || ctc != 0) seen = 1'b1;
    end
    check("idle 20 clks", seen, 0, 0);

    run_cal(1'b0);
    run_cal(1'b1);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Abort: open a gate, let it count, then reset asynchronously.
    do_reset(2'b00, 2'b00);
    @(posedge clk);
    brq = 1'b1;
    repeat (2) @(posedge clk);
    #1.5;
    for (int t = 1; t <= 6; t++) begin
      #7;
      toggle(1'b0);
    end
    repeat (2) @(negedge clk);
    check("abort bac open", bac, 1, 1);
    brq = 1'b0;
    repeat (3) @(negedge clk);
    check("abort bac after brq drop", bac, 1, 1);
    check("abort cta mid-gate", cta, 2, 2);
    check("abort ctc mid-gate", ctc, 1, 15);
    #1.3 rst = 1'b1;
    #0.2;
    check("abort flags cleared", {bac, eac, bip, eip, bin, ein}, 0, 0);
    check("abort counts cleared", {cta, ctc}, 0, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    check("abort no eac", {bac, eac, cta}, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
